// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : uart_pkg
// Shared widths, transmit sequencer states and helpers for the UART loopback.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int DROP_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } tx_state_e;

  // Saturating increment so the drop counter parks at all-ones.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : sync_fifo
// Single-clock circular-buffer FIFO with occupancy count and full/empty flags.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             w_push;
  logic             w_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_loopback_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : uart_loopback_fifo
// Queues received UART bytes and replays them to the transmitter one by one.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module uart_loopback_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_I,
  input  logic                   rec_readyH,
  input  logic [UART_DATA_W-1:0] rec_dataH,
  input  logic                   recv_error,
  output logic                   xmitH,
  output logic [UART_DATA_W-1:0] xmit_dataH,
  input  logic                   xmit_doneH,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflowH,
  output logic [DROP_CNT_W-1:0]  drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  tx_state_e              state_q, state_d;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
  logic                   rdy_q;
  logic                   xmit_q, xmit_d;
  logic [UART_DATA_W-1:0] xmit_data_q, xmit_data_d;
  logic                   ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0]  drop_q, drop_d;

  logic                   w_push_evt;
  logic                   w_push_req;
  logic                   w_drop;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [UART_DATA_W-1:0] w_head;
  logic [AW:0]            w_count;

  assign w_push_evt = rec_readyH & ~rdy_q;
  assign w_push_req = w_push_evt & ~recv_error;
  assign w_drop     = w_push_evt & (recv_error | (w_full & ~w_pop));

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst_I),
    .push_i    (w_push_req),
    .wr_data_i (rec_dataH),
    .pop_i     (w_pop),
    .rd_data_o (w_head),
    .count_o   (w_count),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    w_pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = SEND;
      SEND: begin
        if (xmit_doneH) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and accounting next-state; the request follows the next FSM state.
  always_comb begin
    xmit_d      = (state_d == SEND);
    xmit_data_d = w_pop ? w_head : xmit_data_q;
    ovf_d       = ovf_q | (w_push_req & w_full & ~w_pop);
    drop_d      = w_drop ? sat_inc(drop_q) : drop_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_I) begin
      state_q     <= IDLE;
      gap_cnt_q   <= '0;
      rdy_q       <= 1'b0;
      xmit_q      <= 1'b0;
      xmit_data_q <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      rdy_q       <= rec_readyH;
      xmit_q      <= xmit_d;
      xmit_data_q <= xmit_data_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
    end
  end

  assign xmitH      = xmit_q;
  assign xmit_dataH = xmit_data_q;
  assign fifo_count = w_count;
  assign overflowH  = ovf_q;
  assign drop_count = drop_q;

endmodule
`default_nettype wire
